// File: rtl/pattern_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package pattern_det_pkg;

    localparam int unsigned MAX_LEN_LIMIT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width needed to hold a length value in 0..max_len.
    function automatic int unsigned calc_len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_det_ctrl_if.sv
// Config handshake, control pulses, serial stream and status of the pattern detector.
interface pattern_det_ctrl_if
    import pattern_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = calc_len_w(MAX_LEN)
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               start;
    logic               abort;
    logic               din_valid;
    logic               din;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               err_cfg;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_thresh, start, abort, din_valid, din,
        input  cfg_ready, match, match_cnt, busy, done, err_cfg
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_thresh, start, abort, din_valid, din,
        output cfg_ready, match, match_cnt, busy, done, err_cfg
    );
endinterface

// File: rtl/pattern_match_core.sv
// History shift register, saturating bit counter and length-masked comparator.
module pattern_match_core
    import pattern_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit_c
);
    // The oldest history bit is never compared, so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;

    always_comb begin
        hist_n  = {hist_q, din};
        cnt_inc = (cnt_q == LEN_W'(MAX_LEN)) ? cnt_q : cnt_q + LEN_W'(1);
        mask    = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit_c = shift_en && (cnt_inc >= len) && ((hist_n & mask) == (pattern & mask));

        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (clear) begin
            hist_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            hist_d = hist_n[MAX_LEN-2:0];
            cnt_d  = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern-detection controller: config handshake, arm/abort FSM, match counting.
module pattern_det_ctrl
    import pattern_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    pattern_det_ctrl_if.slave   bus
);
    localparam int unsigned CW1 = CNT_W + 1;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic               cfg_ok_q, cfg_ok_d;
    logic               err_cfg_q, err_cfg_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clear;
    logic               shift_en;
    logic               hit_c;

    pattern_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (shift_en),
        .din      (bus.din),
        .pattern  (pattern_q),
        .len      (len_q),
        .hit_c    (hit_c)
    );

    // Next-state, config latch and match bookkeeping.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        thresh_d    = thresh_q;
        cfg_ok_d    = cfg_ok_q;
        err_cfg_d   = err_cfg_q;
        match_cnt_d = match_cnt_q;
        match_d     = 1'b0;
        done_d      = 1'b0;
        clear       = 1'b0;
        shift_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid && cfg_ready_q) begin
                    pattern_d = bus.cfg_pattern;
                    len_d     = bus.cfg_len;
                    thresh_d  = bus.cfg_thresh;
                    if ((bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN))) begin
                        err_cfg_d = 1'b1;
                        cfg_ok_d  = 1'b0;
                    end else begin
                        err_cfg_d = 1'b0;
                        cfg_ok_d  = 1'b1;
                    end
                end else if (bus.start && cfg_ok_q) begin
                    state_d     = RUN;
                    clear       = 1'b1;
                    match_cnt_d = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.din_valid) begin
                    shift_en = 1'b1;
                    if (hit_c) begin
                        match_d     = 1'b1;
                        match_cnt_d = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
                        if ((thresh_q != '0) &&
                            (({1'b0, match_cnt_q} + CW1'(1)) == {1'b0, thresh_q})) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            thresh_q    <= '0;
            cfg_ok_q    <= 1'b0;
            err_cfg_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            thresh_q    <= thresh_d;
            cfg_ok_q    <= cfg_ok_d;
            err_cfg_q   <= err_cfg_d;
            cfg_ready_q <= cfg_ready_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_cfg   = err_cfg_q;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed table-driven bench for pattern_det_ctrl plus hand-written abort/reset/handshake sequences.
module tb_pattern_det_ctrl;
    import pattern_det_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pattern_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

    pattern_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] thr;
        logic       st;
        logic       ab;
        logic       dv;
        logic       d;
        logic       e_rdy;
        logic       e_m;
        logic [7:0] e_cnt;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cv, input logic [7:0] pat, input logic [3:0] len,
                                input logic [7:0] thr, input logic st, input logic ab,
                                input logic dv, input logic d, input logic e_rdy, input logic e_m,
                                input logic [7:0] e_cnt, input logic e_busy, input logic e_done,
                                input logic e_err);
        vec_t v;
        v.cv = cv; v.pat = pat; v.len = len; v.thr = thr; v.st = st; v.ab = ab;
        v.dv = dv; v.d = d; v.e_rdy = e_rdy; v.e_m = e_m; v.e_cnt = e_cnt;
        v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [7:0] pat, input logic [3:0] len,
                         input logic [7:0] thr, input logic st, input logic ab,
                         input logic dv, input logic d);
        bus.cfg_valid   = cv;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_thresh  = thr;
        bus.start       = st;
        bus.abort       = ab;
        bus.din_valid   = dv;
        bus.din         = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic m, input logic [7:0] cnt,
                           input logic bsy, input logic dn, input logic er);
        chk({tag, " cfg_ready"}, 32'(bus.cfg_ready), 32'(rdy));
        chk({tag, " match"},     32'(bus.match),     32'(m));
        chk({tag, " match_cnt"}, 32'(bus.match_cnt), 32'(cnt));
        chk({tag, " busy"},      32'(bus.busy),      32'(bsy));
        chk({tag, " done"},      32'(bus.done),      32'(dn));
        chk({tag, " err_cfg"},   32'(bus.err_cfg),   32'(er));
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Overlap and completion: 110011, len 6, thresh 2
        tbl.push_back(mk(1, 8'h33, 4'd6, 8'd2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 1, 1, 2, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0));
        // Illegal config then start, then a legal max-length config
        tbl.push_back(mk(1, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 8'hFF, 4'd9, 8'd0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 8'hFF, 4'd8, 8'd0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // Nine 1s with a gap cycle (din=0, not valid) after each
        for (int k = 1; k <= 9; k++) begin
            logic [7:0] c;
            c = (k < 8) ? 8'd0 : ((k == 8) ? 8'd1 : 8'd2);
            tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, (k >= 8), c, 1, 0, 0));
            tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0, c, 1, 0, 0));
        end
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0));

        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        chk_all("reset", 1, 0, 8'd0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("post_reset", 1, 0, 8'd0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cv, tbl[i].pat, tbl[i].len, tbl[i].thr,
                  tbl[i].st, tbl[i].ab, tbl[i].dv, tbl[i].d);
            tick();
            chk_all($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_m, tbl[i].e_cnt,
                    tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
        end

        // Abort on the cycle of the final pattern bit drops that bit
        drive(1, 8'h05, 4'd3, 8'd0, 0, 0, 0, 0); tick();
        drive(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0); tick();
        chk_all("ab_start", 0, 0, 8'd0, 1, 0, 0);
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1); tick();
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0); tick();
        drive(0, 8'h00, 4'd0, 8'd0, 0, 1, 1, 1); tick();
        chk_all("ab_last", 1, 0, 8'd0, 0, 0, 0);
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0); tick();
        chk_all("ab_after", 1, 0, 8'd0, 0, 0, 0);

        // Restart with retained config, then asynchronous reset two bits in
        drive(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0); tick();
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1); tick();
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0); tick();
        chk_all("rst_pre", 0, 0, 8'd0, 1, 0, 0);
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst_async", 1, 0, 8'd0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0); tick();
        chk_all("rst_start_ign", 1, 0, 8'd0, 0, 0, 0);
        drive(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0); tick();
        chk_all("rst_idle", 1, 0, 8'd0, 0, 0, 0);

        // Config held during RUN is taken only after returning to IDLE
        drive(1, 8'h03, 4'd2, 8'd1, 0, 0, 0, 0); tick();
        chk_all("hs_cfg", 1, 0, 8'd0, 0, 0, 0);
        drive(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0); tick();
        chk_all("hs_start", 0, 0, 8'd0, 1, 0, 0);
        drive(1, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1); tick();
        chk_all("hs_bit1", 0, 0, 8'd0, 1, 0, 0);
        drive(1, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1); tick();
        chk_all("hs_bit2", 1, 1, 8'd1, 0, 1, 0);
        drive(1, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0); tick();
        chk_all("hs_accept", 1, 0, 8'd1, 0, 0, 1);
        drive(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0); tick();
        chk_all("hs_start_bad", 1, 0, 8'd1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
